top_2: RTL and testbench

// Self-contained APB subsystem: an internal APB master and an APB slave with a 256x32 word store.
// A change-detect front end writes each new data_i value to the store over APB.
// A compute_req pulse makes the master read back every stored word over APB and sum them.
// The sum is presented on datao, qualified by a one-cycle valido pulse.

---
 rtl/top_2.sv | 278 +++++++++++++++++++++++++++
 tb/tb_top_2.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/top_2.sv
// -----------------------------------------------------------------------------
// top_2 : self-contained APB subsystem
//
// An internal APB3 master talks to an internal APB slave that owns a
// DEPTH x DATA_W word store. A change-detect front end queues every new data_i
// value as an APB write into a circular store. A compute_req pulse makes the
// master read back the first n store slots (n = number of valid entries when
// the request arrived) and sum them. The sum appears on datao together with a
// one-cycle valido strobe.
//
// Ports
//   pclk         in   1       clock, all logic on the rising edge
//   presetn      in   1       asynchronous reset, ACTIVE-HIGH despite the name
//   data_i       in   DATA_W  sample input, may change every cycle
//   compute_req  in   1       one-cycle request to sum the stored words
//   datao        out  DATA_W  last computed sum (held between results)
//   valido       out  1       one-cycle strobe: datao has just been updated
// -----------------------------------------------------------------------------
module top_2 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [DATA_W-1:0] data_i,
    input  logic              compute_req,
    output logic [DATA_W-1:0] datao,
    output logic              valido
);

    // Entry counter needs one extra bit to represent a completely full store.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // ---------------- APB bus (master-driven, registered) ----------------
    apb_state_e          state_q,   state_d;
    logic                psel_q,    psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q,  pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,   paddr_d;
    logic [DATA_W-1:0]   pwdata_q,  pwdata_d;

    // ---------------- APB slave side ----------------
    logic [DATA_W-1:0]   prdata_q;
    logic                pready_s;
    logic                pslverr_s;
    logic [DATA_W-1:0]   store_q [DEPTH];

    // ---------------- change detect / write queue ----------------
    logic [DATA_W-1:0]   last_val_q,  last_val_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                pend_wr_q,   pend_wr_d;
    logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]    count_q,     count_d;

    // ---------------- compute engine ----------------
    logic                busy_q,   busy_d;
    logic                finish_q, finish_d;
    logic [CNT_W-1:0]    n_q,      n_d;
    logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]   acc_q,    acc_d;
    logic [DATA_W-1:0]   datao_q,  datao_d;
    logic                valido_q, valido_d;

    // ---------------- decode ----------------
    logic                change_s;
    logic                xfer_done_s;
    logic                wr_done_s;
    logic                rd_done_s;
    logic                start_s;
    logic                wr_avail_s;
    logic                rd_avail_s;
    logic                launch_wr_s;
    logic                launch_rd_s;

    // The slave never stalls and never errors.
    assign pready_s  = 1'b1;
    assign pslverr_s = 1'b0;

    assign change_s    = (data_i != last_val_q);
    assign xfer_done_s = (state_q == ST_ACCESS) && pready_s;
    assign wr_done_s   = xfer_done_s && pwrite_q;
    assign rd_done_s   = xfer_done_s && !pwrite_q;
    assign start_s     = compute_req && !busy_q;

    // Change detect and write-queue bookkeeping.
    always_comb begin
        last_val_d  = last_val_q;
        pend_data_d = pend_data_q;
        pend_wr_d   = pend_wr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (change_s) begin
            last_val_d  = data_i;
            pend_data_d = data_i;
        end else begin
            last_val_d  = last_val_q;
            pend_data_d = pend_data_q;
        end
        // A value that arrived while its predecessor was already on the bus
        // differs from pwdata, so it must stay pending after this write.
        if (change_s) begin
            pend_wr_d = 1'b1;
        end else if (wr_done_s && (pend_data_q == pwdata_q)) begin
            pend_wr_d = 1'b0;
        end else begin
            pend_wr_d = pend_wr_q;
        end
        if (wr_done_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
        end
    end

    // Compute engine: request capture, accumulation and result publication.
    always_comb begin
        busy_d   = busy_q;
        finish_d = finish_q;
        n_d      = n_q;
        rd_idx_d = rd_idx_q;
        acc_d    = acc_q;
        datao_d  = datao_q;
        valido_d = 1'b0;
        if (start_s) begin
            busy_d   = 1'b1;
            finish_d = 1'b0;
            n_d      = count_q;
            rd_idx_d = '0;
            acc_d    = '0;
        end else if (finish_q) begin
            busy_d   = 1'b0;
            finish_d = 1'b0;
            datao_d  = acc_q;
            valido_d = 1'b1;
        end else if (rd_done_s) begin
            if (!pslverr_s) begin
                acc_d = acc_q + prdata_q;
            end else begin
                acc_d = acc_q;
            end
            rd_idx_d = rd_idx_q + CNT_W'(1);
            if ((rd_idx_q + CNT_W'(1)) == n_q) begin
                finish_d = 1'b1;
            end else begin
                finish_d = 1'b0;
            end
        end else if (busy_q && (n_q == '0)) begin
            // Empty store: nothing to read, publish the zero sum next cycle.
            finish_d = 1'b1;
        end else begin
            finish_d = finish_q;
        end
    end

    // Arbitration uses next-state values so a new transfer can be launched
    // straight out of ACCESS (back-to-back) or on the very request cycle.
    always_comb begin
        wr_avail_s  = pend_wr_d;
        rd_avail_s  = busy_d && !finish_d && (rd_idx_d < n_d);
        launch_wr_s = wr_avail_s;
        launch_rd_s = !wr_avail_s && rd_avail_s;
    end

    // APB master FSM: next state and registered bus signals.
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        case (state_q)
            ST_IDLE, ST_ACCESS: begin
                if ((state_q == ST_IDLE) || pready_s) begin
                    if (launch_wr_s || launch_rd_s) begin
                        state_d   = ST_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        pwrite_d  = launch_wr_s;
                        paddr_d   = launch_wr_s ? wr_ptr_d : rd_idx_d[ADDR_W-1:0];
                        pwdata_d  = launch_wr_s ? pend_data_d : pwdata_q;
                    end else begin
                        state_d   = ST_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        pwrite_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
            end
        endcase
    end

    // State registers for bus, queue and compute engine.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            prdata_q    <= '0;
            last_val_q  <= '0;
            pend_data_q <= '0;
            pend_wr_q   <= 1'b0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            n_q         <= '0;
            rd_idx_q    <= '0;
            acc_q       <= '0;
            datao_q     <= '0;
            valido_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            // Slave read data is fetched during SETUP so it is stable in ACCESS.
            if (psel_q && !penable_q && !pwrite_q) begin
                prdata_q <= store_q[paddr_q];
            end else begin
                prdata_q <= prdata_q;
            end
            last_val_q  <= last_val_d;
            pend_data_q <= pend_data_d;
            pend_wr_q   <= pend_wr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
            n_q         <= n_d;
            rd_idx_q    <= rd_idx_d;
            acc_q       <= acc_d;
            datao_q     <= datao_d;
            valido_q    <= valido_d;
        end
    end

    // Slave word store; contents deliberately survive reset.
    always_ff @(posedge pclk) begin
        if (psel_q && penable_q && pwrite_q && pready_s) begin
            store_q[paddr_q] <= pwdata_q;
        end
    end

    assign datao  = datao_q;
    assign valido = valido_q;

endmodule

// File: tb/tb_top_2.sv
// -----------------------------------------------------------------------------
// tb_top_2 : directed self-checking bench for top_2
// -----------------------------------------------------------------------------
module tb_top_2;

    logic        pclk;
    logic        presetn;
    logic [31:0] data_i;
    logic        compute_req;
    logic [31:0] datao;
    logic        valido;

    int n_checks;
    int n_errors;

    // APB observer state
    logic        pp_sel;
    logic        pp_en;
    logic        pp_wr;
    logic [7:0]  pp_addr;
    logic [31:0] pp_wdata;
    int          viol;
    int          n_wr_xfer;
    int          n_rd_xfer;

    top_2 dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .data_i      (data_i),
        .compute_req (compute_req),
        .datao       (datao),
        .valido      (valido)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // APB protocol observer: sampled mid-cycle, away from the active edge.
    always @(negedge pclk) begin
        logic bad;
        bad = 1'b0;
        if (presetn) begin
            bad = dut.psel_q || dut.penable_q;
        end else begin
            if (dut.penable_q && !dut.psel_q) bad = 1'b1;
            if (dut.penable_q) begin
                if (!(pp_sel && !pp_en)) bad = 1'b1;
                if ((dut.pwrite_q != pp_wr) || (dut.paddr_q != pp_addr) ||
                    (dut.pwdata_q != pp_wdata)) bad = 1'b1;
            end
            if (dut.psel_q && !dut.penable_q && pp_sel && !pp_en) bad = 1'b1;
        end
        viol <= viol + (bad ? 1 : 0);
        if (!presetn && dut.penable_q && dut.pwrite_q) n_wr_xfer <= n_wr_xfer + 1;
        if (!presetn && dut.penable_q && !dut.pwrite_q) n_rd_xfer <= n_rd_xfer + 1;
        pp_sel   <= dut.psel_q;
        pp_en    <= dut.penable_q;
        pp_wr    <= dut.pwrite_q;
        pp_addr  <= dut.paddr_q;
        pp_wdata <= dut.pwdata_q;
    end

    // Issue one compute request and measure latency to valido.
    task automatic run_compute(input string tag, input int exp_lat, input logic [31:0] exp_sum,
                               input int extra_req_at, input int chg_at, input logic [31:0] chg_val);
        int lat;
        bit found;
        @(negedge pclk);
        compute_req = 1'b1;
        @(posedge pclk);
        #1;
        compute_req = 1'b0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 3000) begin
            compute_req = (lat == extra_req_at);
            if (lat == chg_at) data_i = chg_val;
            @(posedge pclk);
            #1;
            lat++;
            if (valido) found = 1'b1;
        end
        compute_req = 1'b0;
        check({tag, "_seen"}, 32'(found), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sum"}, datao, exp_sum);
        @(posedge pclk);
        #1;
        check({tag, "_pulse1"}, 32'(valido), 32'd0);
    endtask

    // Count valido pulses over a window.
    task automatic count_valid(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge pclk);
            #1;
            if (valido) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int wr_base;
        int rd_base;
        n_checks    = 0;
        n_errors    = 0;
        viol        = 0;
        n_wr_xfer   = 0;
        n_rd_xfer   = 0;
        pp_sel      = 1'b0;
        pp_en       = 1'b0;
        pp_wr       = 1'b0;
        pp_addr     = 8'd0;
        pp_wdata    = 32'd0;
        presetn     = 1'b1;
        data_i      = 32'd0;
        compute_req = 1'b0;

        // Reset state
        repeat (2) @(negedge pclk);
        check("rst_datao", datao, 32'd0);
        check("rst_valido", 32'(valido), 32'd0);
        check("rst_psel", 32'(dut.psel_q), 32'd0);
        presetn = 1'b0;
        repeat (2) @(negedge pclk);
        check("post_rst_idle_psel", 32'(dut.psel_q), 32'd0);
        check("post_rst_valido", 32'(valido), 32'd0);

        // Empty store
        run_compute("empty", 2, 32'd0, -1, -1, 32'd0);

        // Fill 23..277
        wr_base = n_wr_xfer;
        for (int v = 23; v <= 277; v++) begin
            @(negedge pclk);
            data_i = 32'(v);
            repeat (7) @(posedge pclk);
        end
        repeat (10) @(negedge pclk);
        check("fill_count", 32'(dut.count_q), 32'd255);
        check("fill_wrptr", 32'(dut.wr_ptr_q), 32'd255);
        check("fill_writes", 32'(n_wr_xfer - wr_base), 32'd255);

        // Compute over 255 entries
        rd_base = n_rd_xfer;
        run_compute("sum1", 511, 32'd38250, -1, -1, 32'd0);
        check("sum1_reads", 32'(n_rd_xfer - rd_base), 32'd255);
        count_valid(200, pulses);
        check("hold_no_valid", 32'(pulses), 32'd0);
        check("hold_datao", datao, 32'd38250);

        // Repeat, no new data
        run_compute("sum2", 511, 32'd38250, -1, -1, 32'd0);

        // Overlap: ignored request plus a write landing in slot 255 (excluded)
        run_compute("ovl", 513, 32'd38250, 10, 20, 32'd1000);
        count_valid(700, pulses);
        check("ovl_ignored_req", 32'(pulses), 32'd0);
        check("ovl_count", 32'(dut.count_q), 32'd256);
        check("ovl_wrptr", 32'(dut.wr_ptr_q), 32'd0);

        // Full store now includes the inserted 1000
        run_compute("full", 513, 32'd39250, -1, -1, 32'd0);

        // Wrap: 300 distinct values after reset
        @(negedge pclk);
        presetn = 1'b1;
        data_i  = 32'd0;
        repeat (2) @(negedge pclk);
        presetn = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge pclk);
            data_i = 32'h8000_0000 + 32'(i);
            repeat (3) @(posedge pclk);
        end
        repeat (10) @(negedge pclk);
        check("wrap_count", 32'(dut.count_q), 32'd256);
        check("wrap_wrptr", 32'(dut.wr_ptr_q), 32'd44);
        // sum over i=45..300 of (2^31 + i) mod 2^32 = 44160
        run_compute("wrap", 513, 32'd44160, -1, -1, 32'd0);

        // Async reset in the middle of a compute
        @(negedge pclk);
        compute_req = 1'b1;
        @(posedge pclk);
        #1;
        compute_req = 1'b0;
        repeat (50) @(posedge pclk);
        #3;
        presetn = 1'b1;
        #1;
        check("arst_datao", datao, 32'd0);
        check("arst_valido", 32'(valido), 32'd0);
        check("arst_psel", 32'(dut.psel_q), 32'd0);
        repeat (2) @(negedge pclk);
        presetn = 1'b0;
        count_valid(600, pulses);
        check("arst_no_valid", 32'(pulses), 32'd0);
        check("arst_datao_after", datao, 32'd0);

        @(negedge pclk);
        check("apb_protocol", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
